// File: rtl/lifo_arbiter.sv
// Two-requester round-robin arbiter owning a shared LIFO stack.
// Grants are combinational; pop data and error status return one cycle later.
module lifo_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_push,
  input  logic              req0_pop,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_push,
  input  logic              req1_pop,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              grant0,
  output logic              grant1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [PTR_W:0]    sp,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e              state;
  logic                lastGrant_q;
  logic [PTR_W:0]      sp_q, sp_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                active0, active1;
  logic                selPush, selPop;
  logic [DATA_W-1:0]   selWdata;
  logic                doPush, doPop, doSwap;
  logic                isFull, isEmpty;
  logic                pushOk, readOk, swapOk, reject;
  logic [PTR_W-1:0]    pushIdx, topIdx;

  assign active0 = req0_push | req0_pop;
  assign active1 = req1_push | req1_pop;

  // lastGrant_q = 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    state = IDLE;
    if (!reset) begin
      if (active0 && active1) state = lastGrant_q ? GRANT0 : GRANT1;
      else if (active0)       state = GRANT0;
      else if (active1)       state = GRANT1;
    end
  end

  assign grant0 = (state == GRANT0);
  assign grant1 = (state == GRANT1);

  always_comb begin
    selPush  = 1'b0;
    selPop   = 1'b0;
    selWdata = '0;
    case (state)
      GRANT0: begin selPush = req0_push; selPop = req0_pop; selWdata = req0_wdata; end
      GRANT1: begin selPush = req1_push; selPop = req1_pop; selWdata = req1_wdata; end
      default: ;
    endcase
  end

  assign isFull  = (sp_q == (PTR_W+1)'(DEPTH));
  assign isEmpty = (sp_q == '0);
  assign doPush  = selPush & ~selPop;
  assign doPop   = selPop & ~selPush;
  assign doSwap  = selPush & selPop;
  assign pushOk  = doPush & ~isFull;
  assign swapOk  = doSwap & ~isEmpty;
  assign readOk  = (doPop | doSwap) & ~isEmpty;
  assign reject  = (doPush & isFull) | ((doPop | doSwap) & isEmpty);
  // When sp == DEPTH the low bits wrap to 0, so topIdx still lands on DEPTH-1.
  assign pushIdx = sp_q[PTR_W-1:0];
  assign topIdx  = sp_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    sp_d = sp_q;
    if (pushOk)                  sp_d = sp_q + (PTR_W+1)'(1);
    else if (doPop && !isEmpty)  sp_d = sp_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q        <= '0;
      lastGrant_q <= 1'b1;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      rvalid0_q <= grant0 & readOk;
      rvalid1_q <= grant1 & readOk;
      err0_q    <= grant0 & reject;
      err1_q    <= grant1 & reject;
      if (grant0)      lastGrant_q <= 1'b0;
      else if (grant1) lastGrant_q <= 1'b1;
      if (readOk)      rdata_q <= mem_q[topIdx];
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (pushOk)      mem_q[pushIdx] <= selWdata;
    else if (swapOk) mem_q[topIdx]  <= selWdata;
  end

  assign sp      = sp_q;
  assign full    = isFull;
  assign empty   = isEmpty;
  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomised and directed bench for lifo_arbiter against a queue-based stack model.
module tb_lifo_arbiter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0_push = 1'b0, req0_pop = 1'b0;
  logic              req1_push = 1'b0, req1_pop = 1'b0;
  logic [DATA_W-1:0] req0_wdata = '0, req1_wdata = '0;
  logic              grant0, grant1, rvalid0, rvalid1, err0, err1, full, empty;
  logic [DATA_W-1:0] rdata;
  logic [PTR_W:0]    sp;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  logic [DATA_W-1:0] stk[$];
  int                lastWinner;
  int                grantedId;
  logic              expRv0, expRv1, expErr0, expErr1;
  logic [DATA_W-1:0] expRdata;

  lifo_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .req0_push(req0_push), .req0_pop(req0_pop), .req0_wdata(req0_wdata),
    .req1_push(req1_push), .req1_pop(req1_pop), .req1_wdata(req1_wdata),
    .grant0(grant0), .grant1(grant1), .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
    .sp(sp), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    stk.delete();
    lastWinner = 1;
    expRdata   = '0;
    expRv0 = 0; expRv1 = 0; expErr0 = 0; expErr1 = 0;
  endtask

  task automatic checkState();
    checkOutput("rvalid0", rvalid0, expRv0);
    checkOutput("rvalid1", rvalid1, expRv1);
    checkOutput("err0", err0, expErr0);
    checkOutput("err1", err1, expErr1);
    checkOutput("rdata", rdata, expRdata);
    checkOutput("sp", sp, stk.size());
    checkOutput("full", full, stk.size() == DEPTH);
    checkOutput("empty", empty, stk.size() == 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    {req0_push, req0_pop, req1_push, req1_pop} = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_grant0", grant0, 0);
    checkOutput("rst_grant1", grant1, 0);
    checkState();
    reset = 1'b0;
  endtask

  // Drive one cycle of requests (called just after a negedge), check grants,
  // then step the model and check the registered responses one cycle later.
  task automatic applyStimulus(input logic p0, input logic o0, input logic [DATA_W-1:0] d0,
                               input logic p1, input logic o1, input logic [DATA_W-1:0] d1);
    logic a0, a1, p, o;
    logic [DATA_W-1:0] d;
    req0_push = p0; req0_pop = o0; req0_wdata = d0;
    req1_push = p1; req1_pop = o1; req1_wdata = d1;
    #1;
    a0 = p0 | o0;
    a1 = p1 | o1;
    grantedId = -1;
    if (a0 && a1) grantedId = (lastWinner == 0) ? 1 : 0;
    else if (a0)  grantedId = 0;
    else if (a1)  grantedId = 1;
    checkOutput("grant0", grant0, grantedId == 0);
    checkOutput("grant1", grant1, grantedId == 1);
    expRv0 = 0; expRv1 = 0; expErr0 = 0; expErr1 = 0;
    if (grantedId >= 0) begin
      logic rv, er;
      rv = 0; er = 0;
      lastWinner = grantedId;
      p = (grantedId == 0) ? p0 : p1;
      o = (grantedId == 0) ? o0 : o1;
      d = (grantedId == 0) ? d0 : d1;
      if (p && !o) begin
        if (stk.size() == DEPTH) er = 1;
        else stk.push_back(d);
      end else if (o && !p) begin
        if (stk.size() == 0) er = 1;
        else begin expRdata = stk.pop_back(); rv = 1; end
      end else begin
        if (stk.size() == 0) er = 1;
        else begin
          expRdata = stk[stk.size()-1];
          stk[stk.size()-1] = d;
          rv = 1;
        end
      end
      if (grantedId == 0) begin expRv0 = rv; expErr0 = er; end
      else                begin expRv1 = rv; expErr1 = er; end
    end
    @(negedge clk);
    checkState();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  initial begin
    logic       pend0, pend1, rp0, ro0, rp1, ro1;
    logic [7:0] rd0, rd1;
    int         n0, n1;

    modelReset();
    doReset();

    // Push three, pop two, from requester 0
    applyStimulus(1, 0, 8'hA1, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'hB2, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'hC3, 0, 0, 8'h00);
    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("tp1_pop_C3", rdata, 8'hC3);
    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("tp1_pop_B2", rdata, 8'hB2);
    checkOutput("tp1_sp1", sp, 1);
    idleCycle();

    // Both push every cycle: alternation starting with requester 0
    doReset();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 8'h10 + 8'(n0), 1, 0, 8'h20 + 8'(n1));
      checkOutput("alt_order", grantedId, i % 2);
      if (grantedId == 0) n0++; else n1++;
    end
    // Full: requester 1 push rejected
    applyStimulus(0, 0, 8'h00, 1, 0, 8'h55);
    checkOutput("full_err1", err1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("empty_err0", err0, 1);

    // Swap: 0x11,0x22 then swap 0x99 by requester 1
    applyStimulus(1, 0, 8'h11, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'h22, 0, 0, 8'h00);
    applyStimulus(0, 0, 8'h00, 1, 1, 8'h99);
    checkOutput("swap_rdata", rdata, 8'h22);
    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("swap_pop1", rdata, 8'h99);
    applyStimulus(0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("swap_pop2", rdata, 8'h11);
    applyStimulus(1, 1, 8'h42, 0, 0, 8'h00);
    checkOutput("swap_empty_err", err0, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 1, 0, 8'h30 + 8'(i));
    applyStimulus(0, 0, 8'h00, 1, 1, 8'h77);
    checkOutput("swap_full_rv1", rvalid1, 1);
    checkOutput("swap_full_sp", sp, DEPTH);

    // Reset during a granted pop
    doReset();
    applyStimulus(1, 0, 8'h01, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'h02, 0, 0, 8'h00);
    applyStimulus(1, 0, 8'h03, 0, 0, 8'h00);
    req0_push = 0; req0_pop = 1;
    #1;
    checkOutput("midrst_grant_pre", grant0, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_grant_gated", grant0, 0);
    req0_pop = 0;
    modelReset();
    @(negedge clk);
    checkState();
    reset = 1'b0;
    applyStimulus(1, 0, 8'h5A, 0, 0, 8'h00);
    checkOutput("midrst_push_sp", sp, 1);

    // Random traffic with request-hold protocol
    pend0 = 0; pend1 = 0;
    rp0 = 0; ro0 = 0; rp1 = 0; ro1 = 0; rd0 = '0; rd1 = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!pend0) begin
        int r = $urandom_range(0, 99);
        rd0 = 8'($urandom);
        rp0 = (r < 40) || (r >= 75 && r < 85);
        ro0 = (r >= 40 && r < 85);
        pend0 = rp0 | ro0;
      end
      if (!pend1) begin
        int r = $urandom_range(0, 99);
        rd1 = 8'($urandom);
        rp1 = (r < 40) || (r >= 75 && r < 85);
        ro1 = (r >= 40 && r < 85);
        pend1 = rp1 | ro1;
      end
      applyStimulus(rp0, ro0, rd0, rp1, ro1, rd1);
      if (grantedId == 0) begin pend0 = 0; rp0 = 0; ro0 = 0; end
      if (grantedId == 1) begin pend1 = 0; rp1 = 0; ro1 = 0; end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Two-requester arbiter and sequencer for a shared LIFO stack. It owns the stack storage and stack pointer, and grants one push, pop or swap per cycle to one of two requesters under round-robin arbitration. Pop data and error status return as registered one-cycle pulses routed to the granted requester. It sits between independent producer/consumer blocks and the single stack resource they share.

## Interface
- DATA_W, 8, width of one stack entry
- DEPTH, 16, number of entries; power of two, ≥2
- PTR_W, 4, log2(DEPTH); occupancy counter is PTR_W+1 bits

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state below
- req0_push  in  1  requester 0 push request
- req0_pop  in  1  requester 0 pop request
- req0_wdata  in  DATA_W  requester 0 push data
- req1_push  in  1  requester 1 push request
- req1_pop  in  1  requester 1 pop request
- req1_wdata  in  DATA_W  requester 1 push data
- grant0  out  1  combinational; requester 0 operation accepted this cycle
- grant1  out  1  combinational; requester 1 operation accepted this cycle
- rdata  out  DATA_W  registered popped/swapped-out value
- rvalid0  out  1  registered; rdata belongs to requester 0
- rvalid1  out  1  registered; rdata belongs to requester 1
- err0  out  1  registered one-cycle pulse; requester 0 op rejected
- err1  out  1  registered one-cycle pulse; requester 1 op rejected
- sp  out  PTR_W+1  occupancy, 0..DEPTH
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0

## Operation
- Requester N is active when reqN_push or reqN_pop is high. A requester holds its request and data stable until it sees grantN high at a rising edge, then drops or changes it.
- Arbitration: at most one grant per cycle. One active requester → granted. Both active → the one not granted most recently wins. Register last_grant resets to 1, so requester 0 wins the first tie.
- Op decode for the granted requester:
  - push only: mem[sp] ← wdata; sp+1.
  - pop only: rdata ← mem[sp-1]; sp-1.
  - push+pop (swap): rdata ← mem[sp-1]; mem[sp-1] ← wdata; sp unchanged.
- Rejections; grant is still given, the request is consumed, and stack/mem are unchanged:
  - push when full → errN.
  - pop when empty → errN.
  - swap when empty → errN.
- Swap when full is legal.
- Only a successful pop or swap produces rvalidN. Push success produces no response pulse.
- States: IDLE (no grant), GRANT0, GRANT1, decoded combinationally each cycle from requests and last_grant. There is no multi-cycle lock.
- rdata holds its last value when no rvalid is asserted.

## Timing
- Reset (async assert, sync-safe release): sp=0, empty=1, full=0, grant0/1=0, rvalid0/1=0, err0/1=0, rdata=0, last_grant=1. mem contents are not cleared.
- Grant path: grantN is high in cycle t, in the same cycle as the qualifying request. There are no wait states.
- sp, full, empty and mem update at the edge ending cycle t.
- rvalidN/errN/rdata are valid in cycle t+1 for exactly one cycle. Pop-to-data latency is 1.
- Back-to-back grants are allowed every cycle, including the same requester on consecutive cycles when the other is idle.
- A pop in cycle t+1 following a push in cycle t returns the just-pushed value (no bypass hazard; mem written at edge t).
- Reset asserted mid-operation: any grant in that cycle is discarded, response pulses are cleared immediately, and sp returns to 0.
- full/empty are derived from registered sp and are glitch-free.

## Test plan
- Reset, then req0 pushes 0xA1, 0xB2, 0xC3 on consecutive cycles → grant0 each cycle, sp 1,2,3. Then req0 pops twice → rvalid0 with rdata 0xC3 then 0xB2, sp=1.
- req0 and req1 both push every cycle from reset → grants alternate 0,1,0,1, with grant0 first. mem order matches the grant order.
- DEPTH=4: fill to full=1, then req1 push 0x55 → grant1, err1 pulse next cycle, sp stays 4, top unchanged. Empty the stack, then req0 pop → err0, sp stays 0, rvalid0 low.
- Stack holds 0x11,0x22; req1 swap with 0x99 → rvalid1 rdata=0x22, sp=2. A following pop returns 0x99, the next pop returns 0x11.
- Swap on empty stack → err pulse, sp=0. Swap on full stack → succeeds, sp=DEPTH.
- Push 3 entries, then assert reset mid-pop (grant high) → rvalid not asserted, sp=0, empty=1. The next push after release lands at sp 0→1.
